// File: rtl/ipcore_rr_arbiter.sv
// rtl/ipcore_rr_arbiter.sv - round-robin arbiter that shares one ipcore between N_REQ requesters
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   req_valid/req_data     per-requester operand requests (requester i at [i*DATA_W +: DATA_W])
//   req_ready              one-hot accept strobe, combinational in IDLE
//   rsp_valid/rsp_data     one-hot one-cycle response strobe plus result
//   rsp_err                1 when the transaction timed out
//   core_start/core_data   start pulse and held operand towards the ipcore
//   core_done/core_result  ipcore completion and result, honoured only in WAIT
//   grant_id               index of the current owner
//   busy                   high in every state except IDLE
module ipcore_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ*DATA_W-1:0]               req_data,
    output logic [N_REQ-1:0]                      req_ready,
    output logic [N_REQ-1:0]                      rsp_valid,
    output logic [DATA_W-1:0]                     rsp_data,
    output logic                                  rsp_err,
    output logic                                  core_start,
    output logic [DATA_W-1:0]                     core_data,
    input  logic                                  core_done,
    input  logic [DATA_W-1:0]                     core_result,
    output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] grant_id,
    output logic                                  busy
);

    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // A zero-width timer is illegal, so TIMEOUT = 0 still gets one (unused) bit.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  core_data_q, core_data_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [GID_W-1:0]   winner;
    logic [GID_W-1:0]   cand;
    logic               any_req;

    // Search from last_grant+1 upward; iterating the offsets downward lets the
    // smallest matching offset (the highest-priority requester) be assigned last.
    always_comb begin
        winner  = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = GID_W'((int'(last_grant_q) + k) % N_REQ);
            if (req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        core_data_d  = core_data_q;
        timer_d      = timer_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        rsp_valid    = '0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    core_data_d       = req_data[int'(winner)*DATA_W +: DATA_W];
                    grant_id_d        = winner;
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the timeout cycle takes precedence over the timeout.
                if (core_done) begin
                    rsp_data_d = core_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1))) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                rsp_valid[grant_id_q] = 1'b1;
                last_grant_d          = grant_id_q;
                state_d               = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= GID_W'(N_REQ - 1);
            grant_id_q   <= '0;
            core_data_q  <= '0;
            timer_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            core_data_q  <= core_data_d;
            timer_q      <= timer_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Decoded from state so an asynchronous reset kills a pending start at once.
    assign core_start = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign core_data  = core_data_q;
    assign grant_id   = grant_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ipcore_rr_arbiter.sv
// tb/tb_ipcore_rr_arbiter.sv - randomized self-checking bench for ipcore_rr_arbiter
module tb_ipcore_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            core_start;
    logic [DW-1:0]   core_data;
    logic            core_done = 1'b0;
    logic [DW-1:0]   core_result = '0;
    logic [1:0]      grant_id;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int last_grant = N - 1;

    ipcore_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_data(core_data),
        .core_done(core_done), .core_result(core_result),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference priority: first set bit after the previous owner, wrapping.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    // dly = cycles from core_start to core_done (0 = never); junk = done pulse in IDLE/ISSUE.
    task automatic run_txn(input logic [N-1:0] mask, input int dly,
                           input logic [DW-1:0] res, input bit junk);
        int w, dc, tc, rc;
        logic [DW-1:0] d [N];
        logic [N-1:0] oh;
        bit err;
        w = model_pick(mask);
        oh = '0;
        oh[w] = 1'b1;
        for (int i = 0; i < N; i++) begin
            d[i] = $urandom;
            req_data[i*DW +: DW] = d[i];
        end
        req_valid = mask;
        if (junk) begin
            core_done   = 1'b1;
            core_result = ~res;
        end
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(oh));
        chk("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("core_start", 64'(core_start), 64'd1);
        chk("core_data", 64'(core_data), 64'(d[w]));
        chk("grant_id", 64'(grant_id), 64'(w));
        // Cycle numbering: accept = 0, start = 1, WAIT from 2; timeout decided on cycle 1+TMO.
        dc  = (dly >= 1) ? 1 + dly : 100000;
        tc  = 1 + TMO;
        err = (dc > tc);
        rc  = err ? tc + 1 : dc + 1;
        for (int c = 2; c < rc; c++) begin
            @(posedge clk); #1;
            core_done   = (c == dc);
            core_result = (c == dc) ? res : DW'($urandom);
            @(negedge clk);
            chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("wait_core_start", 64'(core_start), 64'd0);
        end
        @(posedge clk); #1;
        core_done   = 1'b0;
        core_result = $urandom;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_data", 64'(rsp_data), err ? 64'd0 : 64'(res));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        chk("resp_busy", 64'(busy), 64'd1);
        last_grant = w;
        @(posedge clk); #1;
    endtask

    // Reset asserted during ISSUE (at=1) or WAIT (at>=2); transaction must vanish.
    task automatic reset_mid(input logic [N-1:0] mask, input int at);
        req_valid = mask;
        @(posedge clk); #1;
        req_valid = '0;
        for (int c = 1; c < at; c++) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        last_grant = N - 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_core_start", 64'(core_start), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_core_data", 64'(core_data), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(4'b0001, 3, 32'h1234, 1'b0);
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 1, DW'($urandom), 1'b0);
        run_txn(4'b0100, 0, 32'h0, 1'b0);
        run_txn(4'b0100, TMO, 32'hBEEF, 1'b0);
        run_txn(4'b0010, TMO + 1, 32'hCAFE, 1'b0);
        run_txn(4'b1000, 2, 32'h5A5A, 1'b1);
        run_txn(4'b0001, 0, 32'h0, 1'b1);

        reset_mid(4'b0010, 3);
        run_txn(4'b1100, 2, 32'h7777, 1'b0);
        reset_mid(4'b1000, 1);
        run_txn(4'b1111, 1, 32'h1111, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            run_txn(m, $urandom_range(0, TMO + 2), DW'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
